fpu_bist: RTL and testbench
===========================

Name: fpu_bist

Overview:
- Synthesizable self-test initiator for the bfloat16 fpu; the hardware counterpart of the simulation driver/checker.
- Streams operand pairs and golden results from an external synchronous vector ROM into the fpu at one vector per cycle.
- Compares every result exactly and reports pass/fail, error count and first-failure details.
- Sits beside the fpu in the test wrapper; the fpu remains the responder.

Parameters:
- ADDR_W, 8: vector ROM address width; maximum run is 2^ADDR_W vectors.
- FPU_LATENCY, 0: fpu cycles from operands to result; legal range 0..4, where 0 means combinational.
- CNT_W, 16: width of the error and overflow counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a run; sampled only in IDLE.
- mode_sel_i  in  4  one-hot operation: 0001 add, 0010 sub, 0100 mul, 1000 div.
- num_vec_i  in  ADDR_W+1  number of vectors to run, 0..2^ADDR_W.
- vec_addr_o  out  ADDR_W  ROM read address; data returns one cycle later.
- vec_a_i  in  16  operand A from ROM.
- vec_b_i  in  16  operand B from ROM.
- vec_gold_i  in  16  golden result for the selected mode.
- fpu_mode_o  out  4  to fpu mode_i.
- fpu_in1_o  out  16  to fpu in1_i.
- fpu_in2_o  out  16  to fpu in2_i.
- fpu_out_i  in  16  from fpu out_o.
- fpu_ovf_i  in  1  from fpu overflow_o.
- busy_o  out  1  run in progress.
- done_o  out  1  run finished; held until the next accepted start_i or rst.
- pass_o  out  1  valid when done_o=1; 1 iff err_cnt_o=0 and bad_mode_o=0.
- bad_mode_o  out  1  mode_sel_i was not one-hot when start_i was accepted.
- err_cnt_o  out  CNT_W  number of mismatches, saturating.
- ovf_cnt_o  out  CNT_W  number of compared cycles with fpu_ovf_i=1, saturating.
- first_err_idx_o  out  ADDR_W  vector index of the first mismatch.
- first_err_got_o  out  16  fpu result at the first mismatch.

Behaviour:
- Reset values: all outputs 0, including vec_addr_o, fpu_mode_o and the fpu operands; state IDLE.
- rst mid-run aborts immediately to these values; no done_o is produced.
- States: IDLE -> ISSUE -> DRAIN -> DONE.
- IDLE with start_i=1:
  - Clear all counters and the first-error registers; clear done_o.
  - Latch mode_sel_i and num_vec_i.
  - If the mode is not one-hot: go to DONE with bad_mode_o=1, pass_o=0.
  - Else if num_vec_i=0: go to DONE with pass_o=1.
  - Else: go to ISSUE with address 0; busy_o=1 from the next cycle.
- fpu_mode_o drives the latched mode from start acceptance until the next start or rst.
- Pipeline for the address issued in cycle c:
  - cycle c+1: ROM data is valid.
  - end of c+1: data is registered into fpu_in1_o/fpu_in2_o; golden and index enter the delay line.
  - cycle c+2: operands are visible to the fpu.
  - cycle c+2+FPU_LATENCY: compare fpu_out_i against golden; the comparison is registered at the end of that cycle.
- ISSUE: vec_addr_o increments every cycle; after issuing address num_vec_i-1, go to DRAIN. vec_addr_o holds its last value until the next run.
- DRAIN: operands hold their last value; leave DRAIN when the delay line has no valid entries.
  - Total run time: num_vec_i+2+FPU_LATENCY cycles from ISSUE entry to the DONE transition.
- Compare rule:
  - Exact 16-bit equality; no NaN or sign-of-zero tolerance.
  - Mismatch: err_cnt_o+1 (saturating at all-ones).
  - First mismatch only: capture first_err_idx_o and first_err_got_o.
  - fpu_ovf_i=1 in a compare cycle: ovf_cnt_o+1 (saturating); overflow is never a failure.
- DONE: busy_o=0, done_o=1; counters and first-error registers hold. start_i returns to IDLE handling in the same cycle, so back-to-back runs are allowed.
- start_i while busy_o=1 is ignored; mode_sel_i and num_vec_i changes during a run are ignored.
- num_vec_i=2^ADDR_W: the address wraps only after the final issue and is never reused in that run.

Decomposition:
- Shared package fpu_bist_pkg:
  - MODE_ADD/SUB/MUL/DIV one-hot constants; BF16_W=16.
  - State enum; is_onehot4 function.
- One sub-module fpu_bist_delay: parameterized-depth shift register (depth FPU_LATENCY+1) carrying {valid, index, golden}; depth 1 when FPU_LATENCY=0.

Test Plan:
- ADD, 4 vectors of 3F80+3F80, golden 4000, correct fpu -> done after 6 cycles (LAT=0), pass_o=1, err_cnt_o=0.
- MUL 4000*4040, golden 40C0; vector 2 golden corrupted to 40C1 -> err_cnt_o=1, first_err_idx_o=2, first_err_got_o=40C0, pass_o=0.
- FPU_LATENCY=3 model, DIV 4040/4000, golden 3FC0, 10 vectors -> pass_o=1; done_o rises exactly 15 cycles after ISSUE entry.
- mode_sel_i=0011 with start_i -> next cycle done_o=1, bad_mode_o=1, pass_o=0, vec_addr_o stays 0.
- num_vec_i=0 -> done_o=1, pass_o=1; start_i pulsed mid-run is ignored; rst at vector 5 clears all outputs to 0.
- SUB 4040-3F80, golden 4000, 300 mismatches with CNT_W=8 -> err_cnt_o saturates at FF; fpu_ovf_i forced to 1 on 3 compare cycles -> ovf_cnt_o=3.

Source files
------------

// File: rtl/fpu_bist_pkg.sv
// Shared types and constants for the bfloat16 fpu self-test initiator.
// Holds one-hot mode codes, the run-state enum and a mode legality check.
package fpu_bist_pkg;

  localparam int BF16_W = 16;

  localparam logic [3:0] MODE_ADD = 4'b0001;
  localparam logic [3:0] MODE_SUB = 4'b0010;
  localparam logic [3:0] MODE_MUL = 4'b0100;
  localparam logic [3:0] MODE_DIV = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic is_onehot4(
    input logic [3:0] m
  );
    logic ok;
    ok = 1'b0;
    case (m)
      MODE_ADD, MODE_SUB,
      MODE_MUL, MODE_DIV: ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fpu_bist_delay.sv
// Fixed-depth shift register aligning {valid, data} with fpu latency.
// Ports: in_valid/in_data enter, out_valid/out_data leave after DEPTH
// cycles; pend flags valid entries still short of the output stage.
module fpu_bist_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         pend
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

  generate
    if (DEPTH > 1) begin : g_pend
      assign pend = |vld_q[DEPTH-2:0];
    end else begin : g_nopend
      assign pend = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fpu_bist.sv
// Self-test initiator: streams ROM vectors into the fpu, checks results.
// Ports: start/mode/count in, ROM addr/data, fpu drive/return, status out.
module fpu_bist
  import fpu_bist_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int FPU_LATENCY = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [3:0]        mode_sel_i,
  input  logic [ADDR_W:0]   num_vec_i,
  output logic [ADDR_W-1:0] vec_addr_o,
  input  logic [15:0]       vec_a_i,
  input  logic [15:0]       vec_b_i,
  input  logic [15:0]       vec_gold_i,
  output logic [3:0]        fpu_mode_o,
  output logic [15:0]       fpu_in1_o,
  output logic [15:0]       fpu_in2_o,
  input  logic [15:0]       fpu_out_i,
  input  logic              fpu_ovf_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              bad_mode_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  ovf_cnt_o,
  output logic [ADDR_W-1:0] first_err_idx_o,
  output logic [15:0]       first_err_got_o
);

  localparam int NW = ADDR_W + 1;
  localparam int DW = ADDR_W + BF16_W;

  state_e state_q, state_d;

  logic              accept;
  logic              mode_ok;
  logic              last_issue;
  logic [NW-1:0]     num_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mode_q;
  logic              bad_q;
  logic              rd_vld_q;
  logic [ADDR_W-1:0] rd_idx_q;
  logic [15:0]       in1_q, in2_q;
  logic [CNT_W-1:0]  err_q, ovf_q;
  logic [ADDR_W-1:0] fidx_q;
  logic [15:0]       fgot_q;

  logic              cmp_vld;
  logic [DW-1:0]     cmp_dat;
  logic              dl_pend;
  logic [15:0]       cmp_gold;
  logic [ADDR_W-1:0] cmp_idx;

  assign accept  = start_i &&
                   (state_q == ST_IDLE ||
                    state_q == ST_DONE);
  assign mode_ok = is_onehot4(mode_sel_i);

  // Address never advances past the final vector, so it cannot wrap.
  assign last_issue =
    ({1'b0, addr_q} == num_q - NW'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          if (!mode_ok)
            state_d = ST_DONE;
          else if (num_vec_i == '0)
            state_d = ST_DONE;
          else
            state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (last_issue) state_d = ST_DRAIN;
      end
      // Leave once the entry at the compare stage is the last one.
      ST_DRAIN: begin
        if (!rd_vld_q && !dl_pend)
          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fpu_bist_delay #(
    .DEPTH (FPU_LATENCY + 1),
    .W     (DW)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_vld_q),
    .in_data   ({rd_idx_q, vec_gold_i}),
    .out_valid (cmp_vld),
    .out_data  (cmp_dat),
    .pend      (dl_pend)
  );

  assign cmp_gold = cmp_dat[BF16_W-1:0];
  assign cmp_idx  = cmp_dat[DW-1:BF16_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q    <= '0;
      addr_q   <= '0;
      mode_q   <= '0;
      bad_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      err_q    <= '0;
      ovf_q    <= '0;
      fidx_q   <= '0;
      fgot_q   <= '0;
    end else begin
      rd_vld_q <= (state_q == ST_ISSUE);
      rd_idx_q <= addr_q;
      if (rd_vld_q) begin
        in1_q <= vec_a_i;
        in2_q <= vec_b_i;
      end
      if (accept) begin
        mode_q <= mode_sel_i;
        num_q  <= num_vec_i;
        bad_q  <= !mode_ok;
        addr_q <= '0;
        err_q  <= '0;
        ovf_q  <= '0;
        fidx_q <= '0;
        fgot_q <= '0;
      end else begin
        if (state_q == ST_ISSUE && !last_issue)
          addr_q <= addr_q + 1'b1;
        if (cmp_vld) begin
          if (fpu_out_i != cmp_gold) begin
            if (err_q == '0) begin
              fidx_q <= cmp_idx;
              fgot_q <= fpu_out_i;
            end
            if (err_q != '1)
              err_q <= err_q + 1'b1;
          end
          if (fpu_ovf_i && ovf_q != '1)
            ovf_q <= ovf_q + 1'b1;
        end
      end
    end
  end

  assign vec_addr_o      = addr_q;
  assign fpu_mode_o      = mode_q;
  assign fpu_in1_o       = in1_q;
  assign fpu_in2_o       = in2_q;
  assign busy_o          = (state_q == ST_ISSUE) ||
                           (state_q == ST_DRAIN);
  assign done_o          = (state_q == ST_DONE);
  assign pass_o          = done_o && (err_q == '0) &&
                           !bad_q;
  assign bad_mode_o      = bad_q;
  assign err_cnt_o       = err_q;
  assign ovf_cnt_o       = ovf_q;
  assign first_err_idx_o = fidx_q;
  assign first_err_got_o = fgot_q;

endmodule

// File: tb/tb_fpu_bist.sv
// Bench for fpu_bist: two instances (latency 0 and 3) against a ROM
// and fpu stand-in, with a run-level expectation model.
module tb_fpu_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s0_start = 1'b0;
  logic       s3_start = 1'b0;
  logic [3:0] mode_sel = 4'b0001;
  logic [9:0] num_vec  = '0;

  logic [15:0] rom_a [512];
  logic [15:0] rom_b [512];
  logic [15:0] rom_g [512];

  // stand-in fpu behaviour for the operand pairs used here
  function automatic logic [15:0] fpu_fn(
    input logic [3:0] m, input logic [15:0] a,
    input logic [15:0] b);
    if (m == 4'b0001 && a == 16'h3F80 && b == 16'h3F80)
      return 16'h4000;
    if (m == 4'b0010 && a == 16'h4040 && b == 16'h3F80)
      return 16'h4000;
    if (m == 4'b0100 && a == 16'h4000 && b == 16'h4040)
      return 16'h40C0;
    if (m == 4'b1000 && a == 16'h4040 && b == 16'h4000)
      return 16'h3FC0;
    return a ^ b;
  endfunction

  function automatic logic ovf_fn(input logic [15:0] a);
    return a == 16'h7F7F;
  endfunction

  // instance 0: ADDR_W=9, LAT=0, CNT_W=8
  logic [8:0]  u0_addr, u0_fidx;
  logic [3:0]  u0_mode;
  logic [15:0] u0_in1, u0_in2, u0_fgot;
  logic [15:0] r0_a, r0_b, r0_g, f0_out;
  logic        f0_ovf;
  logic        u0_busy, u0_done, u0_pass, u0_bad;
  logic [7:0]  u0_err, u0_ovf;

  always @(posedge clk) begin
    r0_a <= rom_a[u0_addr];
    r0_b <= rom_b[u0_addr];
    r0_g <= rom_g[u0_addr];
  end
  assign f0_out = fpu_fn(u0_mode, u0_in1, u0_in2);
  assign f0_ovf = ovf_fn(u0_in1);

  fpu_bist #(.ADDR_W(9), .FPU_LATENCY(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start_i(s0_start),
    .mode_sel_i(mode_sel), .num_vec_i(num_vec),
    .vec_addr_o(u0_addr), .vec_a_i(r0_a),
    .vec_b_i(r0_b), .vec_gold_i(r0_g),
    .fpu_mode_o(u0_mode), .fpu_in1_o(u0_in1),
    .fpu_in2_o(u0_in2), .fpu_out_i(f0_out),
    .fpu_ovf_i(f0_ovf), .busy_o(u0_busy),
    .done_o(u0_done), .pass_o(u0_pass),
    .bad_mode_o(u0_bad), .err_cnt_o(u0_err),
    .ovf_cnt_o(u0_ovf), .first_err_idx_o(u0_fidx),
    .first_err_got_o(u0_fgot));

  // instance 3: ADDR_W=4, LAT=3, CNT_W=16
  logic [3:0]  u3_addr, u3_fidx;
  logic [3:0]  u3_mode;
  logic [15:0] u3_in1, u3_in2, u3_fgot;
  logic [15:0] r3_a, r3_b, r3_g;
  logic [15:0] p3 [3];
  logic        q3 [3];
  logic        u3_busy, u3_done, u3_pass, u3_bad;
  logic [15:0] u3_err, u3_ovf;

  always @(posedge clk) begin
    r3_a  <= rom_a[u3_addr];
    r3_b  <= rom_b[u3_addr];
    r3_g  <= rom_g[u3_addr];
    p3[0] <= fpu_fn(u3_mode, u3_in1, u3_in2);
    q3[0] <= ovf_fn(u3_in1);
    p3[1] <= p3[0];
    q3[1] <= q3[0];
    p3[2] <= p3[1];
    q3[2] <= q3[1];
  end

  fpu_bist #(.ADDR_W(4), .FPU_LATENCY(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .start_i(s3_start),
    .mode_sel_i(mode_sel), .num_vec_i(num_vec[4:0]),
    .vec_addr_o(u3_addr), .vec_a_i(r3_a),
    .vec_b_i(r3_b), .vec_gold_i(r3_g),
    .fpu_mode_o(u3_mode), .fpu_in1_o(u3_in1),
    .fpu_in2_o(u3_in2), .fpu_out_i(p3[2]),
    .fpu_ovf_i(q3[2]), .busy_o(u3_busy),
    .done_o(u3_done), .pass_o(u3_pass),
    .bad_mode_o(u3_bad), .err_cnt_o(u3_err),
    .ovf_cnt_o(u3_ovf), .first_err_idx_o(u3_fidx),
    .first_err_got_o(u3_fgot));

  // observed instance
  logic        sel = 1'b0;
  logic        o_busy, o_done, o_pass, o_bad;
  logic [15:0] o_addr, o_err, o_ovf, o_fidx, o_fgot;
  logic [3:0]  o_mode;
  assign o_busy = sel ? u3_busy : u0_busy;
  assign o_done = sel ? u3_done : u0_done;
  assign o_pass = sel ? u3_pass : u0_pass;
  assign o_bad  = sel ? u3_bad  : u0_bad;
  assign o_mode = sel ? u3_mode : u0_mode;
  assign o_addr = sel ? 16'(u3_addr) : 16'(u0_addr);
  assign o_err  = sel ? u3_err : 16'(u0_err);
  assign o_ovf  = sel ? u3_ovf : 16'(u0_ovf);
  assign o_fidx = sel ? 16'(u3_fidx) : 16'(u0_fidx);
  assign o_fgot = sel ? u3_fgot : u0_fgot;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // run-level expectations
  int exp_n, exp_lat, exp_err, exp_ovf;
  int exp_fidx, exp_fgot, exp_pass, exp_bad;
  logic [3:0] exp_mode;
  bit chk_en = 1'b0;
  int cyc = 0;
  bit timed = 1'b0;
  int last_len = 0;

  task automatic compute_expect(input logic [3:0] m,
                                input int n, input int cmax);
    logic [15:0] r;
    exp_mode = m;
    exp_n = n;
    exp_err = 0;
    exp_ovf = 0;
    exp_fidx = 0;
    exp_fgot = 0;
    exp_bad = ($countones(m) != 1);
    if (!exp_bad) begin
      for (int i = 0; i < n; i++) begin
        r = fpu_fn(m, rom_a[i], rom_b[i]);
        if (r != rom_g[i]) begin
          if (exp_err == 0) begin
            exp_fidx = i;
            exp_fgot = r;
          end
          if (exp_err < cmax) exp_err++;
        end
        if (ovf_fn(rom_a[i]) && exp_ovf < cmax)
          exp_ovf++;
      end
    end
    exp_pass = (!exp_bad && exp_err == 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("fpu_mode", o_mode, exp_mode);
      if (o_busy) begin
        chk("done_while_busy", o_done, 0);
        chk("vec_addr", o_addr,
            (cyc < exp_n - 1) ? cyc : exp_n - 1);
        cyc++;
      end
      if (o_done) begin
        chk("busy_while_done", o_busy, 0);
        chk("err_cnt", o_err, exp_err);
        chk("ovf_cnt", o_ovf, exp_ovf);
        chk("pass", o_pass, exp_pass);
        chk("bad_mode", o_bad, exp_bad);
        if (exp_err > 0) begin
          chk("first_idx", o_fidx, exp_fidx);
          chk("first_got", o_fgot, exp_fgot);
        end
        if (!timed && cyc > 0) begin
          chk("run_len", cyc, exp_n + 2 + exp_lat);
          last_len = cyc;
          timed = 1'b1;
        end
      end
    end else begin
      cyc = 0;
      timed = 1'b0;
    end
  end

  task automatic set_start(input bit s, input bit v);
    if (s) s3_start = v;
    else   s0_start = v;
  endtask

  task automatic fill(input int n, input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [15:0] g);
    for (int i = 0; i < n; i++) begin
      rom_a[i] = a;
      rom_b[i] = b;
      rom_g[i] = g;
    end
  endtask

  task automatic run(input bit s, input logic [3:0] m,
                     input int n, input int mid);
    bit seen;
    @(negedge clk);
    chk_en = 1'b0;
    sel = s;
    exp_lat = s ? 3 : 0;
    compute_expect(m, n, s ? 65535 : 255);
    mode_sel = m;
    num_vec = 10'(n);
    set_start(s, 1'b1);
    @(posedge clk);
    #1;
    set_start(s, 1'b0);
    chk_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (mid > 0 && i == mid) begin
        set_start(s, 1'b1);
        mode_sel = 4'b1000;
        num_vec = 10'd7;
      end else begin
        set_start(s, 1'b0);
        mode_sel = m;
        num_vec = 10'(n);
      end
      if (o_done) seen = 1'b1;
    end
    set_start(s, 1'b0);
    chk("done_seen", seen, 1'b1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_mode"}, o_mode, 0);
    chk({tag, "_in1"}, u0_in1, 0);
    chk({tag, "_in2"}, u0_in2, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_bad"}, o_bad, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_ovf"}, o_ovf, 0);
    chk({tag, "_fidx"}, o_fidx, 0);
    chk({tag, "_fgot"}, o_fgot, 0);
  endtask

  initial begin
    fill(512, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // illegal mode straight after reset
    run(1'b0, 4'b0011, 4, 0);
    chk("badmode_done", u0_done, 1);
    chk("badmode_flag", u0_bad, 1);
    chk("badmode_pass", u0_pass, 0);
    chk("badmode_addr", u0_addr, 0);

    // ADD, all correct
    fill(4, 16'h3F80, 16'h3F80, 16'h4000);
    run(1'b0, 4'b0001, 4, 0);
    chk("add_len", last_len, 6);
    chk("add_pass", u0_pass, 1);
    chk("add_err", u0_err, 0);

    // MUL with one corrupted golden, start pulse mid-run
    fill(4, 16'h4000, 16'h4040, 16'h40C0);
    rom_g[2] = 16'h40C1;
    run(1'b0, 4'b0100, 4, 2);
    chk("mul_err", u0_err, 1);
    chk("mul_fidx", u0_fidx, 2);
    chk("mul_fgot", u0_fgot, 16'h40C0);
    chk("mul_pass", u0_pass, 0);

    // zero-length run
    run(1'b0, 4'b0001, 0, 0);
    chk("zero_done", u0_done, 1);
    chk("zero_pass", u0_pass, 1);

    // DIV on latency-3 instance, 10 vectors then full 16
    fill(16, 16'h4040, 16'h4000, 16'h3FC0);
    run(1'b1, 4'b1000, 10, 0);
    chk("div_len", last_len, 15);
    chk("div_pass", u3_pass, 1);
    run(1'b1, 4'b1000, 16, 0);
    chk("div16_len", last_len, 21);
    chk("div16_addr", u3_addr, 15);
    chk("div16_pass", u3_pass, 1);

    // SUB, 300 mismatches saturate 8-bit counter
    fill(300, 16'h4040, 16'h3F80, 16'h4001);
    rom_a[10] = 16'h7F7F;
    rom_a[100] = 16'h7F7F;
    rom_a[250] = 16'h7F7F;
    run(1'b0, 4'b0010, 300, 0);
    chk("sat_err", u0_err, 8'hFF);
    chk("sat_ovf", u0_ovf, 3);
    chk("sat_fidx", u0_fidx, 0);
    chk("sat_fgot", u0_fgot, 16'h4000);

    // reset while vector 5 is being issued
    fill(20, 16'h3F80, 16'h3F80, 16'h4000);
    @(negedge clk);
    chk_en = 1'b0;
    sel = 1'b0;
    mode_sel = 4'b0001;
    num_vec = 10'd20;
    s0_start = 1'b1;
    @(negedge clk);
    s0_start = 1'b0;
    for (int i = 0; i < 20 && u0_addr != 9'd5; i++)
      @(negedge clk);
    chk("abort_at5", u0_addr, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("abort");
    repeat (25) @(negedge clk);
    chk("abort_nodone", u0_done, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
